// File: rtl/vram_arbiter.sv
// Single-port character VRAM arbiter: video fetch has priority, CPU uses a
// 4-phase req/ack handshake with a starvation guard that steals a video slot.
module vram_arbiter #(
   parameter int AW           = 11,
   parameter int DW           = 8,
   parameter int STARVE_LIMIT = 16
) (
   input  logic          clk_pxl,
   input  logic          rst,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic [DW-1:0] vid_data,
   output logic          vid_valid,
   output logic          vid_drop,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,
   output logic [AW-1:0] ram_a,
   output logic          ram_we,
   output logic [DW-1:0] ram_d,
   input  logic [DW-1:0] ram_q
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PEND = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_ACK  = 3'd3;
   localparam logic [2:0] S_HOLD = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          we_q, we_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          vvalid_q, vvalid_d;

   logic          issuing;
   logic          force_cpu;
   logic          cpu_win;
   logic          vid_win;
   logic [AW-1:0] iss_addr;
   logic          iss_we;
   logic [DW-1:0] iss_wdata;
   logic [SW-1:0] starve_inc;

   // In IDLE the CPU issues straight from the live bus; afterwards from the latch.
   always_comb begin
      issuing   = !rst && ((state_q == S_IDLE && cpu_req) || state_q == S_PEND);
      iss_addr  = (state_q == S_IDLE) ? cpu_addr  : addr_q;
      iss_we    = (state_q == S_IDLE) ? cpu_we    : we_q;
      iss_wdata = (state_q == S_IDLE) ? cpu_wdata : wdata_q;
      force_cpu = issuing && (starve_q == LIMIT);
      cpu_win   = issuing && (force_cpu || !vid_req);
      vid_win   = !rst && vid_req && !cpu_win;
      starve_inc = (starve_q == LIMIT) ? starve_q : starve_q + SW'(1);
   end

   always_comb begin
      ram_a     = cpu_win ? iss_addr : vid_addr;
      ram_we    = cpu_win && iss_we;
      ram_d     = cpu_win ? iss_wdata : '0;
      vid_drop  = vid_req && cpu_win;
      vid_valid = vvalid_q;
      vid_data  = ram_q;
      cpu_ack   = (state_q == S_ACK);
      cpu_rdata = rdata_q;
   end

   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      addr_d   = addr_q;
      we_d     = we_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      vvalid_d = vid_win;
      case (state_q)
         S_IDLE: begin
            if (cpu_req) begin
               addr_d  = cpu_addr;
               we_d    = cpu_we;
               wdata_d = cpu_wdata;
               if (cpu_win) begin
                  state_d = S_WAIT;
               end else begin
                  state_d  = S_PEND;
                  starve_d = starve_inc;
               end
            end
         end
         S_PEND: begin
            if (cpu_win) begin
               state_d = S_WAIT;
            end else begin
               starve_d = starve_inc;
            end
         end
         S_WAIT: begin
            if (!we_q) begin
               rdata_d = ram_q;
            end
            starve_d = '0;
            state_d  = S_ACK;
         end
         S_ACK: begin
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (!cpu_req) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_pxl) begin
      if (rst) begin
         state_q  <= S_IDLE;
         starve_q <= '0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         vvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         vvalid_q <= vvalid_d;
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: RAM macro stand-in, transaction-level reference
// model with a shadow memory, directed scenarios plus a randomized phase.
module tb_vram_arbiter;

   localparam int AW     = 11;
   localparam int DW     = 8;
   localparam int STARVE = 16;

   logic          clk_pxl = 1'b0;
   logic          rst;
   logic          vid_req;
   logic [AW-1:0] vid_addr;
   logic [DW-1:0] vid_data;
   logic          vid_valid;
   logic          vid_drop;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_ack;
   logic [AW-1:0] ram_a;
   logic          ram_we;
   logic [DW-1:0] ram_d;
   logic [DW-1:0] ram_q;

   int n_chk = 0;
   int n_err = 0;

   vram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(STARVE)) dut (
      .clk_pxl   (clk_pxl),
      .rst       (rst),
      .vid_req   (vid_req),
      .vid_addr  (vid_addr),
      .vid_data  (vid_data),
      .vid_valid (vid_valid),
      .vid_drop  (vid_drop),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ack   (cpu_ack),
      .ram_a     (ram_a),
      .ram_we    (ram_we),
      .ram_d     (ram_d),
      .ram_q     (ram_q)
   );

   always #5 clk_pxl = ~clk_pxl;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // RAM macro: synchronous read of the old contents, write at the edge.
   logic [DW-1:0] mem [2**AW];
   logic          ram_init = 1'b0;
   always @(posedge clk_pxl) begin
      ram_q <= mem[ram_a];
      if (!ram_init) begin
         for (int i = 0; i < 2**AW; i++) mem[i] <= DW'(i);
         ram_init <= 1'b1;
      end else if (ram_we) begin
         mem[ram_a] <= ram_d;
      end
   end

   // Reference model: one open CPU transaction, a shadow memory, counters.
   logic [DW-1:0] shadow [2**AW];
   logic          sh_init = 1'b0;
   int            ncyc = 0;
   logic          m_busy, m_open, m_we, m_vv;
   logic [AW-1:0] m_a;
   logic [DW-1:0] m_d, m_vd, m_rdata, m_rd_new;
   int            m_den, m_ack_at, m_rd_at;
   logic          cw, vw;
   int            ack_cnt = 0;
   int            drop_cnt = 0;
   int            vv_cnt = 0;

   always @(negedge clk_pxl) begin
      if (!sh_init) begin
         for (int i = 0; i < 2**AW; i++) shadow[i] = DW'(i);
         sh_init = 1'b1;
      end
      if (rst) begin
         m_busy = 0; m_open = 0; m_vv = 0; m_den = 0;
         m_ack_at = -100; m_rd_at = -1; m_rdata = '0;
         chk("rst_ram_we", ram_we, 0);
      end else begin
         if (ncyc == m_rd_at) m_rdata = m_rd_new;
         if (!m_busy && cpu_req) begin
            m_busy = 1; m_open = 1; m_den = 0;
            m_we = cpu_we; m_a = cpu_addr; m_d = cpu_wdata;
         end
         cw = m_open && (m_den >= STARVE || !vid_req);
         vw = vid_req && !cw;
         chk("cpu_ack", cpu_ack, ncyc == m_ack_at);
         chk("vid_valid", vid_valid, m_vv);
         if (m_vv) chk("vid_data", vid_data, m_vd);
         chk("cpu_rdata", cpu_rdata, m_rdata);
         chk("vid_drop", vid_drop, vid_req && cw);
         chk("ram_we", ram_we, cw && m_we);
         chk("ram_a", ram_a, cw ? m_a : vid_addr);
         if (cw && m_we) chk("ram_d", ram_d, m_d);
         m_vv = vw;
         if (vw) m_vd = shadow[vid_addr];
         if (cw) begin
            m_open = 0;
            m_ack_at = ncyc + 2;
            if (m_we) shadow[m_a] = m_d;
            else begin
               m_rd_new = shadow[m_a];
               m_rd_at = ncyc + 2;
            end
         end else if (m_open && m_den < STARVE) begin
            m_den++;
         end
         if (m_busy && !m_open && ncyc >= m_ack_at + 1 && !cpu_req) m_busy = 0;
      end
      if (cpu_ack) ack_cnt++;
      if (vid_drop) drop_cnt++;
      if (vid_valid) vv_cnt++;
      ncyc++;
   end

   task automatic step();
      @(posedge clk_pxl);
      #1;
   endtask

   task automatic cpu_xfer(input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, output int lat);
      logic got;
      got = 0;
      lat = 0;
      cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1;
      while (!got && lat < 100) begin
         step();
         lat++;
         if (cpu_ack) got = 1;
      end
      chk("ack_seen", got, 1);
      cpu_req = 0;
      step();
      step();
   endtask

   task automatic vid_burst(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         vid_req = 1;
         vid_addr = AW'(base + i);
         step();
      end
      vid_req = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat, a0, d0, v0;
      logic done;
      rst = 1; vid_req = 0; vid_addr = '0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      repeat (3) step();
      rst = 0;
      step();
      chk("reset_rdata", cpu_rdata, 0);
      chk("reset_ack", cpu_ack, 0);

      // 1: plain write then read
      cpu_xfer(1, 11'h123, 8'hA5, lat);
      chk("t1_wlat", lat, 2);
      cpu_xfer(0, 11'h123, 8'h00, lat);
      chk("t1_rlat", lat, 2);
      chk("t1_rdata", cpu_rdata, 8'hA5);

      // 2: video burst, CPU waits for first free cycle
      d0 = drop_cnt; v0 = vv_cnt;
      fork
         vid_burst(10, 0);
         begin
            repeat (3) step();
            cpu_xfer(0, 11'h040, 8'h00, lat);
         end
      join
      chk("t2_lat", lat, 9);
      chk("t2_rdata", cpu_rdata, 8'h40);
      chk("t2_drops", drop_cnt - d0, 0);
      chk("t2_vvalid", vv_cnt - v0, 10);

      // 3: starvation guard steals one video slot
      d0 = drop_cnt;
      fork
         vid_burst(40, 100);
         cpu_xfer(0, 11'h200, 8'h00, lat);
      join
      chk("t3_lat", lat, 18);
      chk("t3_drops", drop_cnt - d0, 1);

      // 4: 4-phase rule with req held after ack
      a0 = ack_cnt;
      cpu_we = 1; cpu_addr = 11'h050; cpu_wdata = 8'h77; cpu_req = 1;
      lat = 0;
      while (!cpu_ack && lat < 100) begin step(); lat++; end
      repeat (10) step();
      chk("t4_one_ack", ack_cnt - a0, 1);
      cpu_req = 0;
      step();
      cpu_wdata = 8'h88; cpu_addr = 11'h051; cpu_req = 1;
      lat = 0;
      while (!cpu_ack && lat < 100) begin step(); lat++; end
      chk("t4_relat", lat, 2);
      cpu_req = 0;
      step(); step();

      // 5: reset during WAIT of a read abandons it
      cpu_xfer(1, 11'h0AA, 8'h11, lat);
      a0 = ack_cnt;
      cpu_we = 0; cpu_addr = 11'h0AA; cpu_req = 1;
      step();
      rst = 1;
      step();
      rst = 0; cpu_req = 0;
      repeat (4) step();
      chk("t5_noack", ack_cnt - a0, 0);
      chk("t5_rdata", cpu_rdata, 0);
      cpu_xfer(1, 11'h7FF, 8'h3C, lat);
      chk("t5_wlat", lat, 2);
      cpu_xfer(0, 11'h7FF, 8'h00, lat);
      chk("t5_rdback", cpu_rdata, 8'h3C);

      // 6: character-fetch video pattern with CPU writes and readback
      d0 = drop_cnt; a0 = ack_cnt; done = 0;
      fork
         begin
            while (!done) begin
               vid_req = 1;
               vid_addr = AW'($urandom_range(31, 0));
               step();
               vid_req = 0;
               repeat (7) step();
            end
         end
         begin
            for (int i = 0; i < 32; i++) cpu_xfer(1, AW'(i), DW'(i) ^ 8'h55, lat);
            for (int i = 0; i < 32; i++) begin
               cpu_xfer(0, AW'(i), 8'h00, lat);
               chk("t6_rdback", cpu_rdata, DW'(i) ^ 8'h55);
            end
            done = 1;
         end
      join
      chk("t6_acks", ack_cnt - a0, 64);
      chk("t6_drops", drop_cnt - d0, 0);

      // Randomized mix: dense video traffic against random CPU accesses
      done = 0;
      fork
         begin
            while (!done) begin
               vid_req = ($urandom_range(3, 0) != 0);
               vid_addr = AW'($urandom_range(63, 0));
               step();
            end
            vid_req = 0;
         end
         begin
            for (int i = 0; i < 150; i++) begin
               cpu_xfer(1'($urandom), AW'($urandom_range(63, 0)), DW'($urandom), lat);
               repeat ($urandom_range(3, 0)) step();
            end
            done = 1;
         end
      join

      repeat (4) step();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
